// File: rtl/sreg_pkg.sv
// Shared types and default sizing for the serial shift-register driver.
package sreg_pkg;

  typedef enum logic [1:0] {SREG_IDLE, SREG_SHIFT, SREG_LATCH} sreg_state_t;

  localparam int unsigned SREG_DEF_W   = 42;
  localparam int unsigned SREG_DEF_DIV = 4;

endpackage

// File: rtl/sreg_shifter_if.sv
// Request/serial-side bundle of sreg_shifter; sdi/rdata exist only with SREG_READBACK_EN.
interface sreg_shifter_if #(
  parameter int unsigned DATA_W = sreg_pkg::SREG_DEF_W
) ();

  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              abort;
  logic              ready;
  logic              busy;
  logic              sclk;
  logic              sdata;
  logic              latch;
  logic              done;
  logic [DATA_W-1:0] data_out;
`ifdef SREG_READBACK_EN
  logic              sdi;
  logic [DATA_W-1:0] rdata;

  modport master (output start, data_in, abort, sdi,
                  input  ready, busy, sclk, sdata, latch, done, data_out, rdata);
  modport slave  (input  start, data_in, abort, sdi,
                  output ready, busy, sclk, sdata, latch, done, data_out, rdata);
`else
  modport master (output start, data_in, abort,
                  input  ready, busy, sclk, sdata, latch, done, data_out);
  modport slave  (input  start, data_in, abort,
                  output ready, busy, sclk, sdata, latch, done, data_out);
`endif

endinterface

// File: rtl/sreg_clkdiv.sv
// Divides clk into sclk while enabled; strobes mark the mid-bit rise and the bit wrap.
module sreg_clkdiv #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise_stb,
  output logic wrap_stb
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned HALF  = CLK_DIV / 2;

  logic [DIV_W-1:0] r_div_cnt;
  logic [DIV_W-1:0] w_div_cnt_nxt;
  logic             r_sclk;

  // Counter parks at zero whenever the shifter is not going to stay in SHIFT.
  always_comb begin
    w_div_cnt_nxt = '0;
    if (en && !wrap_stb) begin
      w_div_cnt_nxt = r_div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
    end else begin
      r_div_cnt <= w_div_cnt_nxt;
      r_sclk    <= (w_div_cnt_nxt >= DIV_W'(HALF));
    end
  end

  assign sclk     = r_sclk;
  assign rise_stb = (r_div_cnt == DIV_W'(HALF));
  assign wrap_stb = (r_div_cnt == DIV_W'(CLK_DIV - 1));

endmodule

// File: rtl/sreg_shifter.sv
// Serialises a DATA_W-bit word onto sdata/sclk, then strobes latch and pulses done.
// Optional readback of the chain output via sdi/rdata when SREG_READBACK_EN is defined.
module sreg_shifter #(
  parameter int unsigned DATA_W    = sreg_pkg::SREG_DEF_W,
  parameter int unsigned CLK_DIV   = sreg_pkg::SREG_DEF_DIV,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  sreg_shifter_if.slave  bus
);

  import sreg_pkg::*;

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam int unsigned LAT_W = $clog2(CLK_DIV);

  sreg_state_t       r_state, w_next_state;
  logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [LAT_W-1:0]  r_lat_cnt, w_lat_cnt_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt, w_shifted;
  logic              r_sdata, w_sdata_nxt;
  logic              r_latch, w_latch_nxt;
  logic              r_done, w_done_nxt;
  logic              r_ready, r_busy;
  logic              w_next_bit, w_first_bit;
  logic              w_div_en, w_wrap_stb, w_sclk;
`ifdef SREG_READBACK_EN
  logic              w_rise_stb;
  logic [DATA_W-1:0] r_rdata;
`endif

  assign w_div_en = (r_state == SREG_SHIFT) && (w_next_state == SREG_SHIFT);

  sreg_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (w_div_en),
    .sclk     (w_sclk),
`ifdef SREG_READBACK_EN
    .rise_stb (w_rise_stb),
`else
    .rise_stb (),
`endif
    .wrap_stb (w_wrap_stb)
  );

  // Bit-order dependent shift direction and bit selection.
  always_comb begin
    if (LSB_FIRST != 0) begin
      w_shifted   = r_data >> 1;
      w_next_bit  = r_data[1];
      w_first_bit = bus.data_in[0];
    end else begin
      w_shifted   = r_data << 1;
      w_next_bit  = r_data[DATA_W-2];
      w_first_bit = bus.data_in[DATA_W-1];
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_lat_cnt_nxt = r_lat_cnt;
    w_data_nxt    = r_data;
    w_sdata_nxt   = r_sdata;
    w_latch_nxt   = r_latch;
    w_done_nxt    = 1'b0;
    case (r_state)
      SREG_IDLE: begin
        if (bus.start) begin
          w_next_state  = SREG_SHIFT;
          w_data_nxt    = bus.data_in;
          w_bit_cnt_nxt = '0;
          w_lat_cnt_nxt = '0;
          w_sdata_nxt   = w_first_bit;
        end
      end
      SREG_SHIFT: begin
        if (bus.abort) begin
          w_next_state = SREG_IDLE;
          w_sdata_nxt  = 1'b0;
        end else if (w_wrap_stb) begin
          w_data_nxt = w_shifted;
          if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
            w_next_state  = SREG_LATCH;
            w_sdata_nxt   = 1'b0;
            w_latch_nxt   = 1'b1;
            w_lat_cnt_nxt = '0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
            w_sdata_nxt   = w_next_bit;
          end
        end
      end
      SREG_LATCH: begin
        if (bus.abort) begin
          w_next_state = SREG_IDLE;
          w_latch_nxt  = 1'b0;
        end else if (r_lat_cnt == LAT_W'(CLK_DIV - 1)) begin
          w_next_state = SREG_IDLE;
          w_latch_nxt  = 1'b0;
          w_done_nxt   = 1'b1;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt + LAT_W'(1);
        end
      end
      default: begin
        w_next_state = SREG_IDLE;
        w_sdata_nxt  = 1'b0;
        w_latch_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state   <= SREG_IDLE;
      r_bit_cnt <= '0;
      r_lat_cnt <= '0;
      r_data    <= '0;
      r_sdata   <= 1'b0;
      r_latch   <= 1'b0;
      r_done    <= 1'b0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_lat_cnt <= w_lat_cnt_nxt;
      r_data    <= w_data_nxt;
      r_sdata   <= w_sdata_nxt;
      r_latch   <= w_latch_nxt;
      r_done    <= w_done_nxt;
      r_ready   <= (w_next_state == SREG_IDLE);
      r_busy    <= (w_next_state != SREG_IDLE);
    end
  end

`ifdef SREG_READBACK_EN
  // Chain output captured at each sclk rise, assembled in transmission order.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_rdata <= '0;
    end else if ((r_state == SREG_IDLE) && bus.start) begin
      r_rdata <= '0;
    end else if ((r_state == SREG_SHIFT) && w_rise_stb) begin
      if (LSB_FIRST != 0) begin
        r_rdata <= {bus.sdi, r_rdata[DATA_W-1:1]};
      end else begin
        r_rdata <= {r_rdata[DATA_W-2:0], bus.sdi};
      end
    end
  end

  assign bus.rdata = r_rdata;
`endif

  assign bus.ready    = r_ready;
  assign bus.busy     = r_busy;
  assign bus.sclk     = w_sclk;
  assign bus.sdata    = r_sdata;
  assign bus.latch    = r_latch;
  assign bus.done     = r_done;
  assign bus.data_out = r_data;

endmodule

// File: tb/tb_sreg_shifter.sv
// Self-checking bench for sreg_shifter: default instance (42/4/LSB) and a small
// instance (8/2/MSB), checked cycle by cycle against a timing model of the transfer.
module tb_sreg_shifter;
  import sreg_pkg::*;

  localparam int WA = int'(SREG_DEF_W);
  localparam int DA = int'(SREG_DEF_DIV);
  localparam int NA = (WA + 1) * DA + 1;
  localparam int WB = 8;
  localparam int DB = 2;
  localparam int NB = (WB + 1) * DB + 1;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  sreg_shifter_if #(.DATA_W(WA)) bus_a ();
  sreg_shifter_if #(.DATA_W(WB)) bus_b ();

  sreg_shifter #(.DATA_W(WA), .CLK_DIV(DA), .LSB_FIRST(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  sreg_shifter #(.DATA_W(WB), .CLK_DIV(DB), .LSB_FIRST(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

`ifdef SREG_READBACK_EN
  assign bus_a.sdi = bus_a.sdata;
  assign bus_b.sdi = bus_b.sdata;
`endif

  // {ready, busy, sclk, sdata, latch, done}
  logic [5:0] obs_a, obs_b;
  assign obs_a = {bus_a.ready, bus_a.busy, bus_a.sclk, bus_a.sdata, bus_a.latch, bus_a.done};
  assign obs_b = {bus_b.ready, bus_b.busy, bus_b.sclk, bus_b.sdata, bus_b.latch, bus_b.done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs in cycle T+k of a transfer accepted in cycle T.
  function automatic logic [5:0] exp_out(input int w, input int d, input bit lsb,
                                         input logic [63:0] word, input int k);
    int b, p, idx;
    if (k <= w * d) begin
      b   = (k - 1) / d;
      p   = (k - 1) % d;
      idx = lsb ? b : (w - 1 - b);
      return {1'b0, 1'b1, (p >= d / 2), word[idx], 1'b0, 1'b0};
    end
    if (k <= (w + 1) * d) return 6'b010010;
    if (k == (w + 1) * d + 1) return 6'b100001;
    return 6'b100000;
  endfunction

  task automatic run_a(input logic [WA-1:0] w, input int kmax, input bit do_abort,
                       input int noise_k, output int rises);
    logic [5:0] exp_v;
    logic       prev;
    rises = 0;
    prev  = 1'b0;
    @(negedge clk);
    bus_a.data_in = w;
    bus_a.start   = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= kmax; k++) begin
      bus_a.start   = (k == noise_k);
      bus_a.data_in = WA'({$urandom(), $urandom()});
      exp_v = exp_out(WA, DA, 1'b1, 64'(w), k);
      checks++;
      if (obs_a !== exp_v) begin
        errors++;
        $display("FAIL run_a k=%0d word=%h: got %b, expected %b", k, w, obs_a, exp_v);
      end
      if (bus_a.sclk && !prev) rises++;
      prev = bus_a.sclk;
      if (k == 1) begin
        checks++;
        if (bus_a.data_out !== w) begin
          errors++;
          $display("FAIL run_a load: data_out %h, expected %h", bus_a.data_out, w);
        end
      end
      if (k == NA) begin
        checks++;
        if (bus_a.data_out !== '0) begin
          errors++;
          $display("FAIL run_a drained: data_out %h, expected 0", bus_a.data_out);
        end
`ifdef SREG_READBACK_EN
        checks++;
        if (bus_a.rdata !== w) begin
          errors++;
          $display("FAIL run_a rdata: got %h, expected %h", bus_a.rdata, w);
        end
`endif
      end
      if (do_abort && (k == kmax)) bus_a.abort = 1'b1;
      @(posedge clk); #1;
    end
    bus_a.start = 1'b0;
    bus_a.abort = 1'b0;
  endtask

  task automatic run_b(input logic [WB-1:0] w);
    logic [5:0] exp_v;
    @(negedge clk);
    bus_b.data_in = w;
    bus_b.start   = 1'b1;
    @(posedge clk); #1;
    bus_b.start = 1'b0;
    for (int k = 1; k <= NB; k++) begin
      exp_v = exp_out(WB, DB, 1'b0, 64'(w), k);
      checks++;
      if (obs_b !== exp_v) begin
        errors++;
        $display("FAIL run_b k=%0d word=%h: got %b, expected %b", k, w, obs_b, exp_v);
      end
      if (k == 1) begin
        checks++;
        if (bus_b.data_out !== w) begin
          errors++;
          $display("FAIL run_b load: data_out %h, expected %h", bus_b.data_out, w);
        end
      end
      if (k == NB) begin
        checks++;
        if (bus_b.data_out !== '0) begin
          errors++;
          $display("FAIL run_b drained: data_out %h, expected 0", bus_b.data_out);
        end
`ifdef SREG_READBACK_EN
        checks++;
        if (bus_b.rdata !== w) begin
          errors++;
          $display("FAIL run_b rdata: got %h, expected %h", bus_b.rdata, w);
        end
`endif
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #3;
    checks++;
    if (obs_a !== 6'b100000 || bus_a.data_out !== '0) begin
      errors++;
      $display("FAIL reset_a: flags %b data_out %h, expected 100000 and 0", obs_a, bus_a.data_out);
    end
    checks++;
    if (obs_b !== 6'b100000 || bus_b.data_out !== '0) begin
      errors++;
      $display("FAIL reset_b: flags %b data_out %h, expected 100000 and 0", obs_b, bus_b.data_out);
    end
`ifdef SREG_READBACK_EN
    checks++;
    if (bus_a.rdata !== '0) begin
      errors++;
      $display("FAIL reset_rdata: got %h, expected 0", bus_a.rdata);
    end
`endif
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs_a !== 6'b100000) begin
      errors++;
      $display("FAIL reset_release: flags %b, expected 100000", obs_a);
    end
  endtask

  task automatic test_lsb_pattern();
    int r;
    logic [WA-1:0] w;
    w = 42'h155_5555_5555;
    run_a(w, NA, 1'b0, 60, r);
    checks++;
    if (r != WA) begin
      errors++;
      $display("FAIL lsb_rises: got %0d, expected %0d", r, WA);
    end
    for (int i = 0; i < 3; i++) begin
      w = WA'({$urandom(), $urandom()});
      run_a(w, NA, 1'b0, int'($urandom_range(2, NA - 2)), r);
      checks++;
      if (r != WA) begin
        errors++;
        $display("FAIL rand_rises: got %0d, expected %0d", r, WA);
      end
    end
  endtask

  task automatic test_readback();
`ifdef SREG_READBACK_EN
    int r;
    run_a(42'h2AB_CDEF_0123, NA, 1'b0, 0, r);
`endif
  endtask

  task automatic test_msb_order();
    run_b(8'hC3);
    for (int i = 0; i < 3; i++) run_b(WB'($urandom()));
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_v;
    logic [WB-1:0] w;
    int kk;
    @(negedge clk);
    bus_b.data_in = 8'hA5;
    bus_b.start   = 1'b1;
    @(posedge clk); #1;
    bus_b.data_in = 8'h5A;
    for (int k = 1; k <= 2 * NB; k++) begin
      if (k == NB + 1) bus_b.start = 1'b0;
      kk = (k <= NB) ? k : (k - NB);
      w  = (k <= NB) ? 8'hA5 : 8'h5A;
      exp_v = exp_out(WB, DB, 1'b0, 64'(w), kk);
      checks++;
      if (obs_b !== exp_v) begin
        errors++;
        $display("FAIL b2b k=%0d: got %b, expected %b", k, obs_b, exp_v);
      end
      if (k == NB + 1) begin
        checks++;
        if (bus_b.data_out !== 8'h5A) begin
          errors++;
          $display("FAIL b2b second load: data_out %h, expected 5a", bus_b.data_out);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_abort();
    int r;
    logic seen;
    logic [WA-1:0] w;
    w = WA'({$urandom(), $urandom()});
    run_a(w, 9 * DA + DA / 2 + 1, 1'b1, 0, r);
    checks++;
    if (r != 10) begin
      errors++;
      $display("FAIL abort_rises: got %0d, expected 10", r);
    end
    checks++;
    if (obs_a !== 6'b100000 || bus_a.data_out !== (w >> 9)) begin
      errors++;
      $display("FAIL abort_shift: flags %b data_out %h, expected 100000 and %h", obs_a, bus_a.data_out, w >> 9);
    end
    seen = 1'b0;
    for (int k = 0; k < NA; k++) begin
      seen |= bus_a.latch | bus_a.done;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_latch: latch/done seen %b, expected 0", seen);
    end
    // abort while latch is high
    run_a(WA'({$urandom(), $urandom()}), WA * DA + 2, 1'b1, 0, r);
    seen = bus_a.latch | bus_a.done;
    for (int k = 0; k < 2 * DA; k++) begin
      @(posedge clk); #1;
      seen |= bus_a.latch | bus_a.done;
    end
    checks++;
    if (seen !== 1'b0 || obs_a !== 6'b100000) begin
      errors++;
      $display("FAIL abort_latch: seen %b flags %b, expected 0 and 100000", seen, obs_a);
    end
    bus_a.abort = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs_a !== 6'b100000) begin
      errors++;
      $display("FAIL abort_idle: flags %b, expected 100000", obs_a);
    end
    w = WA'({$urandom(), $urandom()});
    bus_a.start   = 1'b1;
    bus_a.data_in = w;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    checks++;
    if (bus_a.busy !== 1'b1 || bus_a.ready !== 1'b0 || bus_a.data_out !== w) begin
      errors++;
      $display("FAIL abort_start_wins: busy %b ready %b data_out %h, expected 1 0 %h",
               bus_a.busy, bus_a.ready, bus_a.data_out, w);
    end
    @(posedge clk); #1;
    bus_a.abort = 1'b0;
    checks++;
    if (obs_a !== 6'b100000) begin
      errors++;
      $display("FAIL abort_shift_idle: flags %b, expected 100000", obs_a);
    end
  endtask

  task automatic test_async_reset();
    int r;
    logic seen;
    run_a(WA'({$urandom(), $urandom()}), 50, 1'b0, 0, r);
    #2;
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs_a !== 6'b100000 || bus_a.data_out !== '0) begin
      errors++;
      $display("FAIL async_reset: flags %b data_out %h, expected 100000 and 0", obs_a, bus_a.data_out);
    end
`ifdef SREG_READBACK_EN
    checks++;
    if (bus_a.rdata !== '0) begin
      errors++;
      $display("FAIL async_reset_rdata: got %h, expected 0", bus_a.rdata);
    end
`endif
    @(negedge clk);
    rst_n = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < NA; k++) begin
      @(posedge clk); #1;
      seen |= bus_a.latch | bus_a.done | bus_a.busy;
    end
    checks++;
    if (seen !== 1'b0 || bus_a.ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_after: seen %b ready %b, expected 0 and 1", seen, bus_a.ready);
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    bus_a.start   = 1'b0;
    bus_a.abort   = 1'b0;
    bus_a.data_in = '0;
    bus_b.start   = 1'b0;
    bus_b.abort   = 1'b0;
    bus_b.data_in = '0;
    test_reset();
    test_lsb_pattern();
    test_readback();
    test_msb_order();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sreg_shifter.md
Name: sreg_shifter

Overview:
- Parametrised serial shift-register driver. Takes a DATA_W-bit word on a valid/ready handshake and serialises it on sdata with a divided sclk.
- Pulses latch after the last bit, then signals done.
- Supports configurable width, clock ratio, bit order and abort.
- Sits between the register-file/config logic and the off-chip shift-register chain.

Parameters:
- DATA_W, 42, word length in bits; must be at least 2.
- CLK_DIV, 4, clk cycles per sclk period; must be even and at least 2.
- LSB_FIRST, 1, 1 = bit 0 shifted first, 0 = bit DATA_W-1 first.
- CNT_W, $clog2(DATA_W), bit-counter width (derived, not overridden).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-high reset (asserted when 1).
- start  in  1  request; accepted when start && ready.
- data_in  in  DATA_W  word to shift; sampled on the accept cycle only.
- abort  in  1  synchronous abort of an in-flight transfer.
- ready  out  1  high in IDLE only.
- busy  out  1  high in SHIFT or LATCH.
- sclk  out  1  serial clock to the chain.
- sdata  out  1  serial data; changes only while sclk is low.
- latch  out  1  storage strobe to the chain.
- done  out  1  one-cycle pulse when a transfer completes normally.
- data_out  out  DATA_W  live shift register contents; shifts toward the output end.

Behaviour:
- Reset values (async, immediate): state=IDLE, ready=1, busy=0, sclk=0, sdata=0, latch=0, done=0, data_out=0, counters=0. All outputs are registered.
- States: IDLE, SHIFT, LATCH.
- IDLE:
  - start && ready at cycle T loads data_out<=data_in, bit_cnt<=0, div_cnt<=0 and moves to SHIFT at T+1.
  - sdata at T+1 is the first bit: data_in[0] when LSB_FIRST=1, else data_in[DATA_W-1].
  - ready drops at T+1. start while not ready is ignored and not queued.
- SHIFT:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - sclk=0 while div_cnt < CLK_DIV/2, else 1. The rising edge is mid-bit, giving CLK_DIV/2 cycles of setup and hold.
  - On the wrap (div_cnt==CLK_DIV-1): data_out shifts one place (zero fill), sdata takes the next bit, bit_cnt increments.
  - On the wrap with bit_cnt==DATA_W-1: go to LATCH, sclk=0, sdata=0.
  - Duration is exactly DATA_W*CLK_DIV cycles, i.e. cycles T+1 .. T+DATA_W*CLK_DIV.
- LATCH:
  - latch=1 for CLK_DIV cycles; sclk stays 0.
  - Then IDLE with done=1 and ready=1 on the same cycle, T+(DATA_W+1)*CLK_DIV+1.
  - A new start is accepted on that cycle, so back-to-back transfers have one idle cycle between them.
- abort (SHIFT or LATCH): next cycle is IDLE, sclk=0, sdata=0, latch=0, done=0, ready=1. data_out holds its partially shifted value. abort in IDLE has no effect. abort and start together in IDLE: start wins.
- Reset mid-transfer: immediate return to the reset values; no latch pulse is emitted.
- Counter rules: bit_cnt and div_cnt saturate logic to their compare values; neither wraps past a bound.

Optional Feature:
- Macro: SREG_READBACK_EN.
- When defined:
  - Adds input sdi (1 bit) and output rdata (DATA_W bits), reset 0.
  - sdi is sampled on every sclk rising-edge cycle (div_cnt==CLK_DIV/2) and shifted into rdata in the same bit order as transmission.
  - rdata is valid when done pulses and holds until the next accept.
  - An aborted transfer leaves rdata partial.
- When undefined: no sdi/rdata ports and no readback logic.

Decomposition:
- Package sreg_pkg holds:
  - typedef enum logic [1:0] sreg_state_t {SREG_IDLE, SREG_SHIFT, SREG_LATCH};
  - localparams SREG_DEF_W=42 and SREG_DEF_DIV=4.
- One sub-module, sreg_clkdiv (parameter CLK_DIV):
  - Inputs: clk, rst_n, en.
  - Outputs: sclk, rise_stb (div_cnt==CLK_DIV/2), wrap_stb (div_cnt==CLK_DIV-1).
  - Counter clears while en=0.

Test Plan:
- Defaults; start at T with data_in=42'h155_5555_5555:
  - sdata sequence 1,0,1,0,... LSB first, 42 sclk rising edges.
  - latch high for 4 cycles starting T+169.
  - done at T+173; ready low T+1..T+172.
- LSB_FIRST=0, DATA_W=8, CLK_DIV=2, data_in=8'hC3: sdata order 1,1,0,0,0,0,1,1; done at T+19.
- Back-to-back: start held high with 8'hA5 then 8'h5A (DATA_W=8): second accept on the first done cycle; sclk stays low through LATCH and the one idle cycle.
- abort asserted at the 10th sclk rise (defaults): next cycle state=IDLE, ready=1, sclk=0; no latch and no done pulse.
- rst_n pulsed high mid-SHIFT: all outputs return to reset values in the same cycle without waiting for clk; ready=1 after release.
- SREG_READBACK_EN with sdi looped to sdata, data_in=42'h2AB_CDEF_0123: rdata==42'h2AB_CDEF_0123 at done.
